keypad_matrix_scan: RTL

KEYPAD_MATRIX_SCAN -- requirements
Module: keypad_matrix_scan

---
 rtl/keypad_matrix_scan.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/keypad_matrix_scan.sv
// keypad_matrix_scan
//   Scans a ROWS x COLS key matrix by driving one column low at a time and
//   reading the active-low row lines. A press is accepted after it has been
//   stable for DEBOUNCE_TICKS scan ticks, and a release is accepted the same
//   way. Optional auto-repeat re-pulses key_press while a key is held.
//
// Ports
//   clk         : single clock, all flops on the rising edge
//   reset_n     : asynchronous active-low reset
//   row         : row lines, active-low, asynchronous to clk
//   col         : column drive, active-low (all low while idle)
//   key_valid   : a debounced key is currently held
//   key_press   : one-clk pulse on press acceptance and on each repeat
//   key_release : one-clk pulse on release acceptance
//   key_value   : row_index*COLS + col_index of the accepted key
//   multi_key   : more than one row was low when the key was captured
module keypad_matrix_scan #(
    parameter int ROWS           = 4,
    parameter int COLS           = 4,
    parameter int CLK_DIV        = 100,
    parameter int DEBOUNCE_TICKS = 10,
    parameter int REPEAT_TICKS   = 0,
    localparam int KEY_W         = $clog2(ROWS * COLS)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [ROWS-1:0]  row,
    output logic [COLS-1:0]  col,
    output logic             key_valid,
    output logic             key_press,
    output logic             key_release,
    output logic [KEY_W-1:0] key_value,
    output logic             multi_key
);

    localparam int CIDX_W = $clog2(COLS);
    localparam int DIV_W  = $clog2(CLK_DIV);
    localparam int CNT_W  = $clog2(DEBOUNCE_TICKS + 2);
    localparam int RPT_W  = $clog2(REPEAT_TICKS + 2);

    localparam logic [ROWS-1:0] ALL_ONES = '1;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SCAN     = 3'd1;
    localparam logic [2:0] S_DEBOUNCE = 3'd2;
    localparam logic [2:0] S_HELD     = 3'd3;
    localparam logic [2:0] S_RELEASE  = 3'd4;

    logic [ROWS-1:0]   syncMeta_q;
    logic [ROWS-1:0]   rowS_q;
    logic [DIV_W-1:0]  divCnt_q;
    logic              tick;

    logic [2:0]        state_q,      state_d;
    logic [CIDX_W-1:0] colIdx_q,     colIdx_d;
    logic [ROWS-1:0]   capRow_q,     capRow_d;
    logic [CNT_W-1:0]  cnt_q,        cnt_d;
    logic [RPT_W-1:0]  rptCnt_q,     rptCnt_d;
    logic              keyValid_q,   keyValid_d;
    logic              keyPress_q,   keyPress_d;
    logic              keyRelease_q, keyRelease_d;
    logic [KEY_W-1:0]  keyValue_q,   keyValue_d;
    logic              multiKey_q,   multiKey_d;

    logic [CNT_W-1:0]  cntInc;
    logic [RPT_W-1:0]  rptInc;
    logic              debounceDone;
    logic              repeatDone;
    logic [KEY_W-1:0]  keyCode;
    logic              multiCode;

    // Two-flop synchroniser; idles at all-ones so reset looks like "no key".
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            syncMeta_q <= '1;
            rowS_q     <= '1;
        end else begin
            syncMeta_q <= row;
            rowS_q     <= syncMeta_q;
        end
    end

    // Scan tick: a one-cycle enable at the last count of each divider period,
    // so the first tick after reset lands CLK_DIV cycles later.
    assign tick = (divCnt_q == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            divCnt_q <= '0;
        end else if (tick) begin
            divCnt_q <= '0;
        end else begin
            divCnt_q <= divCnt_q + DIV_W'(1);
        end
    end

    // Key code from the captured pattern: the lowest low row wins when
    // several rows are low, and multi_key flags that situation.
    always_comb begin
        int lowRow;
        int zeroCount;
        lowRow    = 0;
        zeroCount = 0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (!capRow_q[i]) begin
                lowRow    = i;
                zeroCount = zeroCount + 1;
            end
        end
        keyCode   = KEY_W'(lowRow * COLS + int'(colIdx_q));
        multiCode = (zeroCount > 1);
    end

    // The capture tick counts as the first stable tick, so acceptance needs
    // cnt+1 to reach DEBOUNCE_TICKS, and always at least one matching tick.
    assign cntInc       = cnt_q + CNT_W'(1);
    assign rptInc       = rptCnt_q + RPT_W'(1);
    assign debounceDone = (int'(cntInc) >= DEBOUNCE_TICKS);
    assign repeatDone   = (int'(rptInc) >= REPEAT_TICKS);

    // Scan / debounce state machine; it only moves on tick cycles.
    always_comb begin
        state_d      = state_q;
        colIdx_d     = colIdx_q;
        capRow_d     = capRow_q;
        cnt_d        = cnt_q;
        rptCnt_d     = rptCnt_q;
        keyValid_d   = keyValid_q;
        keyPress_d   = 1'b0;
        keyRelease_d = 1'b0;
        keyValue_d   = keyValue_q;
        multiKey_d   = multiKey_q;

        if (tick) begin
            case (state_q)
                S_IDLE: begin
                    if (rowS_q != ALL_ONES) begin
                        state_d  = S_SCAN;
                        colIdx_d = '0;
                    end
                end
                S_SCAN: begin
                    if (rowS_q != ALL_ONES) begin
                        capRow_d = rowS_q;
                        cnt_d    = CNT_W'(1);
                        state_d  = S_DEBOUNCE;
                    end else if (colIdx_q == CIDX_W'(COLS - 1)) begin
                        state_d = S_IDLE;
                    end else begin
                        colIdx_d = colIdx_q + CIDX_W'(1);
                    end
                end
                S_DEBOUNCE: begin
                    if (rowS_q == capRow_q) begin
                        if (debounceDone) begin
                            state_d    = S_HELD;
                            cnt_d      = '0;
                            rptCnt_d   = '0;
                            keyValid_d = 1'b1;
                            keyPress_d = 1'b1;
                            keyValue_d = keyCode;
                            multiKey_d = multiCode;
                        end else begin
                            cnt_d = cntInc;
                        end
                    end else begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end
                end
                S_HELD: begin
                    if (rowS_q == ALL_ONES) begin
                        state_d  = S_RELEASE;
                        cnt_d    = CNT_W'(1);
                        rptCnt_d = '0;
                    end else if (REPEAT_TICKS > 0) begin
                        if (repeatDone) begin
                            rptCnt_d   = '0;
                            keyPress_d = 1'b1;
                        end else begin
                            rptCnt_d = rptInc;
                        end
                    end
                end
                S_RELEASE: begin
                    if (rowS_q == ALL_ONES) begin
                        if (debounceDone) begin
                            state_d      = S_IDLE;
                            cnt_d        = '0;
                            keyValid_d   = 1'b0;
                            keyRelease_d = 1'b1;
                        end else begin
                            cnt_d = cntInc;
                        end
                    end else begin
                        // A bounce during release returns to HELD silently.
                        state_d  = S_HELD;
                        cnt_d    = '0;
                        rptCnt_d = '0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            colIdx_q     <= '0;
            capRow_q     <= '1;
            cnt_q        <= '0;
            rptCnt_q     <= '0;
            keyValid_q   <= 1'b0;
            keyPress_q   <= 1'b0;
            keyRelease_q <= 1'b0;
            keyValue_q   <= '0;
            multiKey_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            colIdx_q     <= colIdx_d;
            capRow_q     <= capRow_d;
            cnt_q        <= cnt_d;
            rptCnt_q     <= rptCnt_d;
            keyValid_q   <= keyValid_d;
            keyPress_q   <= keyPress_d;
            keyRelease_q <= keyRelease_d;
            keyValue_q   <= keyValue_d;
            multiKey_q   <= multiKey_d;
        end
    end

    // Idle drives every column so any key wakes the scanner; otherwise only
    // the current (or captured) column is driven low.
    assign col = (state_q == S_IDLE) ? '0 : ~(COLS'(1) << colIdx_q);

    assign key_valid   = keyValid_q;
    assign key_press   = keyPress_q;
    assign key_release = keyRelease_q;
    assign key_value   = keyValue_q;
    assign multi_key   = multiKey_q;

endmodule
